// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle: D/E/M operand and destination
// fields in, stall controls and mult/div status out.
interface hazard_ctrl_if;
  logic [4:0]  D_rs_addr;
  logic [4:0]  D_rt_addr;
  logic [1:0]  D_rs_tuse;
  logic [1:0]  D_rt_tuse;
  logic [4:0]  E_wa;
  logic [4:0]  M_wa;
  logic [1:0]  E_tnew;
  logic [1:0]  M_tnew;
  logic        D_md_use;
  logic [1:0]  E_md_start;
  logic        stall;
  logic        PC_en;
  logic        D_en;
  logic        E_clr;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse,
    output E_wa, M_wa, E_tnew, M_tnew, D_md_use, E_md_start,
    input  stall, PC_en, D_en, E_clr, md_busy, stall_cnt
  );

  modport slave (
    input  D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse,
    input  E_wa, M_wa, E_tnew, M_tnew, D_md_use, E_md_start,
    output stall, PC_en, D_en, E_clr, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Tuse/Tnew stall detection plus mult/div busy tracking for a 5-stage MIPS pipe.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave bus
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10,
    MD_RSVD = 2'b11
  } md_op_e;

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             md_busy_q;
  md_op_e           md_op;
  logic             md_issue;
  logic             rs_stall;
  logic             rt_stall;
  logic             md_stall;
  logic             stall;

  // A source stalls when its producer in E or M will not have the value
  // ready by the time this instruction needs it; $0 never carries a value.
  function automatic logic src_stall(
    input logic [4:0] addr,
    input logic [1:0] tuse,
    input logic [4:0] e_wa,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew
  );
    return (tuse != 2'd3) && (addr != 5'd0) &&
           (((e_wa == addr) && (e_tnew > tuse)) ||
            ((m_wa == addr) && (m_tnew > tuse)));
  endfunction

  assign md_op    = md_op_e'(bus.E_md_start);
  assign md_issue = (md_op == MD_MULT) || (md_op == MD_DIV);

  assign rs_stall = src_stall(bus.D_rs_addr, bus.D_rs_tuse,
                              bus.E_wa, bus.E_tnew, bus.M_wa, bus.M_tnew);
  assign rt_stall = src_stall(bus.D_rt_addr, bus.D_rt_tuse,
                              bus.E_wa, bus.E_tnew, bus.M_wa, bus.M_tnew);
  assign md_stall = bus.D_md_use && (md_busy_q || md_issue);
  assign stall    = rs_stall || rt_stall || md_stall;

  assign bus.stall   = stall;
  assign bus.PC_en   = ~stall;
  assign bus.D_en    = ~stall;
  assign bus.E_clr   = stall;
  assign bus.md_busy = md_busy_q;

  // A new issue always (re)loads the counter, so an issue while busy
  // restarts the unit for the new operation.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      md_busy_q <= 1'b0;
    end else if (md_op == MD_MULT) begin
      state     <= MULT;
      cnt       <= CNT_W'(MULT_CYC - 1);
      md_busy_q <= 1'b1;
    end else if (md_op == MD_DIV) begin
      state     <= DIV;
      cnt       <= CNT_W'(DIV_CYC - 1);
      md_busy_q <= 1'b1;
    end else if (state != IDLE) begin
      if (cnt == '0) begin
        state     <= IDLE;
        md_busy_q <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: data hazards, mult/div busy timing,
// reset abort, restart and the optional stall counter.
module tb_hazard_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  hazard_ctrl_if bus ();

  hazard_ctrl #(
    .MULT_CYC(5),
    .DIV_CYC (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; outputs are read 1 ns later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.D_rs_addr  = 5'd0;
    bus.D_rt_addr  = 5'd0;
    bus.D_rs_tuse  = 2'd0;
    bus.D_rt_tuse  = 2'd0;
    bus.E_wa       = 5'd0;
    bus.M_wa       = 5'd0;
    bus.E_tnew     = 2'd0;
    bus.M_tnew     = 2'd0;
    bus.D_md_use   = 1'b0;
    bus.E_md_start = 2'b00;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    #2;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_pc_en", 32'(bus.PC_en), 32'd1);
    check("rst_d_en",  32'(bus.D_en),  32'd1);
    check("rst_e_clr", 32'(bus.E_clr), 32'd0);
    tick();
    check("rst_md_busy",   32'(bus.md_busy), 32'd0);
    check("rst_stall_cnt", bus.stall_cnt,    32'd0);
    reset = 1'b0;

    // Load-use on rs: E producer, then the same value moving through M.
    bus.D_rs_addr = 5'd5; bus.D_rs_tuse = 2'd0;
    bus.E_wa = 5'd5; bus.E_tnew = 2'd2;
    #1;
    check("lu_e_stall", 32'(bus.stall), 32'd1);
    check("lu_e_clr",   32'(bus.E_clr), 32'd1);
    check("lu_pc_en",   32'(bus.PC_en), 32'd0);
    check("lu_d_en",    32'(bus.D_en),  32'd0);
    tick();
    bus.E_tnew = 2'd0; bus.M_wa = 5'd5; bus.M_tnew = 2'd1;
    #1;
    check("lu_m_stall", 32'(bus.stall), 32'd1);
    tick();
    bus.M_tnew = 2'd0;
    #1;
    check("lu_released", 32'(bus.stall), 32'd0);
    check("lu_pc_en_back", 32'(bus.PC_en), 32'd1);

    // rt path through M, with the tnew == tuse boundary.
    clear_inputs();
    bus.D_rt_addr = 5'd7; bus.D_rt_tuse = 2'd1;
    bus.M_wa = 5'd7; bus.M_tnew = 2'd2;
    #1;
    check("rt_m_stall", 32'(bus.stall), 32'd1);
    bus.M_tnew = 2'd1;
    #1;
    check("rt_tnew_eq_tuse", 32'(bus.stall), 32'd0);

    // Writes to $0 never stall.
    clear_inputs();
    bus.D_rt_addr = 5'd0; bus.D_rt_tuse = 2'd0;
    bus.E_wa = 5'd0; bus.E_tnew = 2'd2;
    #1;
    check("zero_reg", 32'(bus.stall), 32'd0);

    // Unused operand (tuse 3) ignores a matching producer.
    clear_inputs();
    bus.D_rs_addr = 5'd9; bus.D_rs_tuse = 2'd3;
    bus.E_wa = 5'd9; bus.E_tnew = 2'd2;
    #1;
    check("unused_rs", 32'(bus.stall), 32'd0);
    bus.D_rs_tuse = 2'd1;
    #1;
    check("used_rs", 32'(bus.stall), 32'd1);

    // Mult: issue at T, busy T+1..T+5, free at T+6.
    clear_inputs();
    tick();
    bus.E_md_start = 2'b01; bus.D_md_use = 1'b1;
    #1;
    check("mult_issue_stall", 32'(bus.stall), 32'd1);
    check("mult_issue_busy",  32'(bus.md_busy), 32'd0);
    tick();
    bus.E_md_start = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("mult_busy_%0d", k),  32'(bus.md_busy), 32'd1);
      check($sformatf("mult_stall_%0d", k), 32'(bus.stall),   32'd1);
      tick();
    end
    check("mult_done_busy",  32'(bus.md_busy), 32'd0);
    check("mult_done_stall", 32'(bus.stall),   32'd0);
    bus.D_md_use = 1'b0;

    // Div aborted by reset on its 4th busy cycle, then a fresh mult.
    bus.E_md_start = 2'b10;
    tick();
    bus.E_md_start = 2'b00;
    #1;
    check("div_no_md_use_stall", 32'(bus.stall), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("div_busy_%0d", k), 32'(bus.md_busy), 32'd1);
      tick();
    end
    check("div_busy_4", 32'(bus.md_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("div_reset_abort", 32'(bus.md_busy), 32'd0);
    bus.E_md_start = 2'b01;
    tick();
    bus.E_md_start = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("remult_busy_%0d", k), 32'(bus.md_busy), 32'd1);
      tick();
    end
    check("remult_done", 32'(bus.md_busy), 32'd0);

    // Div issued on the 2nd busy cycle of a mult restarts as a full div.
    bus.E_md_start = 2'b01;
    tick();
    bus.E_md_start = 2'b00;
    tick();
    bus.E_md_start = 2'b10;
    tick();
    bus.E_md_start = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("restart_div_busy_%0d", k), 32'(bus.md_busy), 32'd1);
      tick();
    end
    check("restart_div_done", 32'(bus.md_busy), 32'd0);

    // Reserved start code behaves as no-op.
    bus.E_md_start = 2'b11; bus.D_md_use = 1'b1;
    #1;
    check("rsvd_stall", 32'(bus.stall), 32'd0);
    tick();
    check("rsvd_busy", 32'(bus.md_busy), 32'd0);
    clear_inputs();

    // Statistics: exactly 7 stalled edges after reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.D_rs_addr = 5'd5; bus.E_wa = 5'd5; bus.E_tnew = 2'd2;
    #1;
    check("stats_stall_on", 32'(bus.stall), 32'd1);
    repeat (7) tick();
    clear_inputs();
    #1;
    check("stats_stall_off", 32'(bus.stall), 32'd0);
    tick();
`ifdef HAZARD_STATS_EN
    check("stats_cnt", bus.stall_cnt, 32'd7);
`else
    check("stats_cnt", bus.stall_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
